pipe_stall_ctrl: RTL and testbench

Central pipeline stall controller for the 5-stage MIPS core. It merges the ID-stage load-use stall request with a multi-cycle EX operation sequencer (divider and multiplier) and drives the shared stall bus that the IF, ID, EX, MEM and WB stage registers sample. The block holds the front of the pipeline while an EX operation runs, signals completion, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 89 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Pipeline stall bus driver merging ID load-use stalls with a
//                multi-cycle EX sequencer; saturating stall-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
   parameter int STALL_W = 6,
   parameter int LEN_W   = 6,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               mc_start,
   input  logic [LEN_W-1:0]   mc_len,
   output logic [STALL_W-1:0] stall,
   output logic               mc_busy,
   output logic               mc_done,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_count;
   logic [LEN_W-1:0] w_len_eff;
   logic             w_ex_hold;

   // A zero length is treated as a single-cycle op.
   assign w_len_eff = (mc_len == '0) ? LEN_W'(1) : mc_len;
   assign w_ex_hold = ((r_state == S_IDLE) && mc_start) || (r_state == S_BUSY);

   always_comb begin
      stall = '0;
      if (w_ex_hold) begin
         stall[3:0] = 4'b1111;
      end else if (stallreq_id) begin
         stall[2:0] = 3'b111;
      end
   end

   assign mc_busy = w_ex_hold;
   assign mc_done = (r_state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mc_start) begin
                  if (w_len_eff == LEN_W'(1)) begin
                     r_state <= S_DONE;
                  end else begin
                     r_count <= w_len_eff - LEN_W'(1);
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_count <= r_count - LEN_W'(1);
               if (r_count == LEN_W'(1)) begin
                  r_state <= S_DONE;
               end
            end
            // mc_start is still driven by the departing op here, so never re-arm.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall[0] && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// Testbench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// checked against a remaining-cycles reference model.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id;
   logic        mc_start;
   logic [5:0]  mc_len;
   logic [5:0]  stall;
   logic        mc_busy;
   logic        mc_done;
   logic [31:0] stall_cnt;
   logic [5:0]  stall_b;
   logic        mc_busy_b;
   logic        mc_done_b;
   logic [3:0]  stall_cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: cycles of EX hold still owed, and whether this is the done cycle.
   int     m_hold = 0;
   bit     m_done = 1'b0;
   longint m_cnt  = 0;
   int     m_cnt4 = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.STALL_W(6), .LEN_W(6), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
      .mc_len(mc_len), .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done),
      .stall_cnt(stall_cnt)
   );

   pipe_stall_ctrl #(.STALL_W(6), .LEN_W(6), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
      .mc_len(mc_len), .stall(stall_b), .mc_busy(mc_busy_b), .mc_done(mc_done_b),
      .stall_cnt(stall_cnt4)
   );

   function automatic int eff_len(input logic [5:0] len);
      return (len == 6'd0) ? 1 : int'(len);
   endfunction

   function automatic bit exp_hold();
      return (m_hold > 0) || (!m_done && mc_start);
   endfunction

   function automatic logic [5:0] exp_stall();
      if (exp_hold())  return 6'b001111;
      if (stallreq_id) return 6'b000111;
      return 6'b000000;
   endfunction

   task automatic tick();
      logic [5:0] es;
      bit         nd;
      es = exp_stall();
      nd = 1'b0;
      @(posedge clk);
      if (rst) begin
         m_hold = 0; m_done = 1'b0; m_cnt = 0; m_cnt4 = 0;
      end else begin
         if (es[0]) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (m_hold > 0) begin
            m_hold--;
            nd = (m_hold == 0);
         end else if (!m_done && mc_start) begin
            m_hold = eff_len(mc_len) - 1;
            nd = (m_hold == 0);
         end
         m_done = nd;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stallreq_id = 1'b0; mc_start = 1'b0; mc_len = 6'd0;
      tick();
      #1;
      n_tests++;
      if (stall !== 6'b000000 || mc_busy !== 1'b0 || mc_done !== 1'b0 || stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hold: stall=%b busy=%b done=%b cnt=%0d, required 000000/0/0/0",
                  stall, mc_busy, mc_done, stall_cnt);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if (stall !== 6'b000000 || mc_busy !== 1'b0 || mc_done !== 1'b0 || stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: stall=%b busy=%b done=%b cnt=%0d, required 000000/0/0/0",
                     i, stall, mc_busy, mc_done, stall_cnt);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      stallreq_id = 1'b1;
      #1;
      n_tests++;
      if (stall !== 6'b000111 || mc_done !== 1'b0 || mc_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL load_use_stall: stall=%b done=%b busy=%b, required 000111/0/0", stall, mc_done, mc_busy);
      end
      tick();
      stallreq_id = 1'b0;
      #1;
      n_tests++;
      if (stall_cnt !== 32'd1 || stall !== 6'b000000 || mc_done !== 1'b0) begin
         n_fail++;
         $display("FAIL load_use_cnt: cnt=%0d stall=%b done=%b, required 1/000000/0", stall_cnt, stall, mc_done);
      end
      tick();
   endtask

   task automatic test_mc_op(input logic [5:0] len, input bit idreq);
      int     l;
      longint c0;
      l  = eff_len(len);
      c0 = m_cnt;
      mc_start = 1'b1; mc_len = len; stallreq_id = idreq;
      for (int i = 0; i < l; i++) begin
         #1;
         n_tests++;
         if (stall !== 6'b001111 || mc_busy !== 1'b1 || mc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL op_len%0d_hold[%0d]: stall=%b busy=%b done=%b, required 001111/1/0",
                     len, i, stall, mc_busy, mc_done);
         end
         tick();
         mc_len = 6'($urandom);
      end
      #1;
      n_tests++;
      if (mc_done !== 1'b1 || mc_busy !== 1'b0 || stall !== (idreq ? 6'b000111 : 6'b000000)
          || stall_cnt !== 32'(c0 + l)) begin
         n_fail++;
         $display("FAIL op_len%0d_done: done=%b busy=%b stall=%b cnt=%0d, required 1/0/%b/%0d",
                  len, mc_done, mc_busy, stall, stall_cnt, (idreq ? 6'b000111 : 6'b000000), c0 + l);
      end
      tick();
      mc_start = 1'b0; stallreq_id = 1'b0;
      #1;
      n_tests++;
      if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 6'b000000
          || stall_cnt !== 32'(c0 + l + (idreq ? 1 : 0))) begin
         n_fail++;
         $display("FAIL op_len%0d_idle: done=%b busy=%b stall=%b cnt=%0d, required 0/0/000000/%0d",
                  len, mc_done, mc_busy, stall, stall_cnt, c0 + l + (idreq ? 1 : 0));
      end
      tick();
   endtask

   task automatic test_reset_mid_op();
      mc_start = 1'b1; mc_len = 6'd20; stallreq_id = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      #1;
      n_tests++;
      if (stall !== 6'b001111 || mc_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_before_rst: stall=%b busy=%b, required 001111/1", stall, mc_busy);
      end
      tick();
      rst = 1'b0; mc_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         n_tests++;
         if (stall !== 6'b000000 || mc_busy !== 1'b0 || mc_done !== 1'b0 || stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_after_rst[%0d]: stall=%b busy=%b done=%b cnt=%0d, required 000000/0/0/0",
                     i, stall, mc_busy, mc_done, stall_cnt);
         end
         tick();
      end
      test_mc_op(6'd3, 1'b0);
   endtask

   task automatic test_saturation();
      rst = 1'b1; mc_start = 1'b0; stallreq_id = 1'b0;
      tick();
      rst = 1'b0; stallreq_id = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_tests++;
         if (stall_cnt4 !== 4'((i > 15) ? 15 : i) || stall_cnt !== 32'(i)) begin
            n_fail++;
            $display("FAIL saturate[%0d]: cnt4=%0d cnt32=%0d, required %0d/%0d",
                     i, stall_cnt4, stall_cnt, (i > 15) ? 15 : i, i);
         end
      end
      stallreq_id = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         stallreq_id = ($urandom_range(0, 2) == 0);
         if (!mc_start) mc_start = ($urandom_range(0, 3) == 0);
         else           mc_start = ($urandom_range(0, 5) != 0);
         mc_len = 6'($urandom_range(0, 9));
         #1;
         n_tests++;
         if (stall !== exp_stall() || mc_busy !== exp_hold() || mc_done !== m_done
             || stall_cnt !== 32'(m_cnt) || stall_cnt4 !== 4'(m_cnt4) || stall_b !== stall
             || mc_busy_b !== mc_busy || mc_done_b !== mc_done) begin
            n_fail++;
            $display("FAIL random[%0d]: stall=%b busy=%b done=%b cnt=%0d cnt4=%0d, required %b/%b/%b/%0d/%0d",
                     i, stall, mc_busy, mc_done, stall_cnt, stall_cnt4,
                     exp_stall(), exp_hold(), m_done, m_cnt, m_cnt4);
         end
         tick();
      end
      rst = 1'b0; mc_start = 1'b0; stallreq_id = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mc_op(6'd33, 1'b0);
      test_mc_op(6'd1, 1'b0);
      test_mc_op(6'd0, 1'b0);
      test_mc_op(6'd4, 1'b1);
      test_reset_mid_op();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
